hci_bank_starv_arbiter: RTL and testbench
=========================================

# hci_bank_starv_arbiter

Per-bank two-requester arbiter with a starvation guard for the TCDM. It sits in front of each memory bank and merges the log-interconnect branch (nominal high priority) with the HWPE router branch (nominal low priority). It applies a programmable priority inversion and a bounded-stall policy, so the losing side is forced through after a configurable number of lost cycles. It also tracks ownership of each accepted transaction and routes the one-cycle-latency bank response back to the correct side with its ID.

## Interface
Parameters:
- AW, 32: bank word-address width.
- DW, 32: data width.
- BW, 8: bits per byte-enable lane; BE width = DW/BW.
- IW, 8: transaction ID width.
- STALL_W, 8: width of the stall threshold and of the stall counter.

Ports (clock and reset first):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of all state.
- invert_prio_i  in  1  0: hi side is primary; 1: lo side is primary.
- max_stall_i  in  STALL_W  starvation threshold; 0 disables forcing.
- hi_req_i / lo_req_i  in  1  request.
- hi_gnt_o / lo_gnt_o  out  1  grant; a handshake is req&gnt in the same cycle.
- hi_add_i / lo_add_i  in  AW  word address.
- hi_wen_i / lo_wen_i  in  1  1 = read, 0 = write.
- hi_data_i / lo_data_i  in  DW  write data.
- hi_be_i / lo_be_i  in  DW/BW  byte enables.
- hi_id_i / lo_id_i  in  IW  transaction ID.
- hi_r_data_o / lo_r_data_o  out  DW  response data, shared copy of mem_r_data_i.
- hi_r_valid_o / lo_r_valid_o  out  1  response valid.
- hi_r_id_o / lo_r_id_o  out  IW  response ID.
- mem_req_o  out  1  bank request.
- mem_gnt_i  in  1  bank grant.
- mem_add_o, mem_wen_o, mem_data_o, mem_be_o, mem_id_o  out  as above  selected request fields.
- mem_r_data_i  in  DW  bank read data, valid one cycle after the handshake.

## Operation
- Terminology:
  - Primary side = hi if invert_prio_i=0, else lo. Secondary side = the other one.
  - Winner = the side whose fields drive mem_*.
- FSM states: NORMAL and FORCE.
  - NORMAL: winner is primary if primary requests; otherwise winner is secondary.
  - FORCE: winner is secondary if secondary requests; otherwise winner is primary.
- mem_req_o = req of the winner. The winner's gnt_o = mem_gnt_i & its req. The loser's gnt_o = 0.
- Stall counter stall_q (STALL_W bits, saturating):
  - Increments in any cycle where the secondary requests while the primary completes a handshake.
  - Clears on any secondary handshake.
  - Clears when the secondary deasserts its req.
- NORMAL -> FORCE at a clock edge when max_stall_i != 0 and the next stall_q value >= max_stall_i.
- FORCE -> NORMAL at a clock edge when the secondary handshakes or the secondary's req is low. stall_q clears on this transition.
- A change of invert_prio_i at a clock edge clears stall_q and returns the FSM to NORMAL.
- With max_stall_i=0 the FSM stays in NORMAL permanently; stall_q still counts.
- Response tracking:
  - On every handshake, read or write, register resp_v_q=1, resp_side_q = winner, resp_id_q = winner's id.
  - Next cycle, the owner's r_valid_o=1 and its r_id_o=resp_id_q. The other side's r_valid_o=0.
  - Both r_data_o always carry mem_r_data_i.
- Back-to-back handshakes each produce a response in consecutive cycles. No buffering is needed.
- clear_i = 1 forces: FSM to NORMAL, stall_q to 0, resp_v_q to 0. It has no effect on the combinational grant in the same cycle.

## Timing
- Request path is combinational: req -> mem_req_o, and mem_gnt_i -> gnt_o in the same cycle.
- Response latency is exactly 1 cycle after the handshake.
- Reset values:
  - FSM = NORMAL, stall_q = 0, resp_v_q = 0, resp_side_q = hi, resp_id_q = 0.
  - All r_valid_o = 0 and r_id_o = 0.
  - gnt_o and mem_req_o follow the inputs and are 0 when no req.
- mem_gnt_i=0: no handshake and no response. stall_q does not increment, because the primary did not complete.
- Reset asserted mid-transaction drops any pending response; no r_valid appears after reset release.
- stall_q saturates at 2^STALL_W-1 and never wraps.
- Lowering max_stall_i below the current stall_q triggers FORCE at the next edge, provided the secondary is still requesting.

## Test plan
- Reset/idle: rst_ni low for 3 cycles, no reqs -> all gnt_o, r_valid_o and mem_req_o are 0; FSM is NORMAL.
- Plain priority: hi and lo request continuously, max_stall_i=0, mem_gnt_i=1 -> hi is granted every cycle and lo is never granted. Set invert_prio_i=1 -> lo is granted from the same cycle.
- Starvation: max_stall_i=3, both request continuously, mem_gnt_i=1 -> grants follow hi,hi,hi,lo,hi,hi,hi,lo… with lo_gnt_o in cycle 4. stall_q returns to 0 after each lo grant.
- Abandoned force: max_stall_i=2; lo deasserts req in the FORCE cycle -> hi is granted in that cycle, and the FSM returns to NORMAL with stall_q=0.
- Response routing: hi reads id 0x11 at cycle N, then lo writes id 0x22 at N+1 (via forcing) -> hi_r_valid_o=1 with hi_r_id_o=0x11 at N+1; lo_r_valid_o=1 with lo_r_id_o=0x22 at N+2.
- Bank backpressure plus clear: mem_gnt_i=0 for 5 cycles with both requesting -> no gnt and stall_q stays constant. Pulse clear_i while in FORCE -> FSM is NORMAL with stall_q=0 on the next cycle.

Source files
------------

// File: rtl/hci_bank_starv_arbiter_if.sv
// hci_bank_starv_arbiter_if: TCDM request/response channel of one bank port
interface hci_bank_starv_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int BW = 8,
   parameter int IW = 8
);
   logic             req;
   logic             gnt;
   logic [AW-1:0]    add;
   logic             wen;
   logic [DW-1:0]    data;
   logic [DW/BW-1:0] be;
   logic [IW-1:0]    id;
   logic [DW-1:0]    r_data;
   logic             r_valid;
   logic [IW-1:0]    r_id;
   modport master (output req, add, wen, data, be, id, input gnt, r_data, r_valid, r_id);
   modport slave  (input req, add, wen, data, be, id, output gnt, r_data, r_valid, r_id);
endinterface

// File: rtl/hci_bank_starv_arbiter.sv
// hci_bank_starv_arbiter: per-bank hi/lo arbiter with starvation forcing and response routing
module hci_bank_starv_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int BW      = 8,
   parameter int IW      = 8,
   parameter int STALL_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     invert_prio_i,
   input  logic [STALL_W-1:0]       max_stall_i,
   hci_bank_starv_arbiter_if.slave  hi,
   hci_bank_starv_arbiter_if.slave  lo,
   hci_bank_starv_arbiter_if.master mem
);
   typedef enum logic {NORMAL, FORCE} state_e;
   state_e             state_q;
   logic [STALL_W-1:0] stall_q, stall_nxt;
   logic               inv_q, resp_v_q, resp_lo_q;
   logic [IW-1:0]      resp_id_q;
   logic               p_req, s_req, win_prim, win_lo, hs, p_hs, s_hs, starve;
   // winner selection, bank-side muxing and response fan-out
   always_comb begin
      p_req     = invert_prio_i ? lo.req : hi.req;
      s_req     = invert_prio_i ? hi.req : lo.req;
      win_prim  = (state_q == NORMAL) ? p_req : ~s_req;
      win_lo    = ~(win_prim ^ invert_prio_i);
      mem.req   = win_lo ? lo.req  : hi.req;
      mem.add   = win_lo ? lo.add  : hi.add;
      mem.wen   = win_lo ? lo.wen  : hi.wen;
      mem.data  = win_lo ? lo.data : hi.data;
      mem.be    = win_lo ? lo.be   : hi.be;
      mem.id    = win_lo ? lo.id   : hi.id;
      hi.gnt    = ~win_lo & hi.req & mem.gnt;
      lo.gnt    = win_lo & lo.req & mem.gnt;
      hs        = mem.req & mem.gnt;
      p_hs      = hs & win_prim;
      s_hs      = hs & ~win_prim;
      stall_nxt = (s_hs | ~s_req) ? '0 : (p_hs && stall_q != '1) ? stall_q + STALL_W'(1) : stall_q;
      starve    = (max_stall_i != '0) && (stall_nxt >= max_stall_i);
      hi.r_data  = mem.r_data;
      lo.r_data  = mem.r_data;
      hi.r_valid = resp_v_q & ~resp_lo_q;
      lo.r_valid = resp_v_q & resp_lo_q;
      hi.r_id    = (resp_v_q & ~resp_lo_q) ? resp_id_q : '0;
      lo.r_id    = (resp_v_q & resp_lo_q) ? resp_id_q : '0;
   end
   // priority FSM, saturating stall counter and one-deep response owner tracking
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= NORMAL;
         stall_q   <= '0;
         inv_q     <= 1'b0;
         resp_v_q  <= 1'b0;
         resp_lo_q <= 1'b0;
         resp_id_q <= '0;
      end else if (clear_i) begin
         state_q  <= NORMAL;
         stall_q  <= '0;
         inv_q    <= invert_prio_i;
         resp_v_q <= 1'b0;
      end else begin
         inv_q    <= invert_prio_i;
         resp_v_q <= hs;
         if (hs) begin
            resp_lo_q <= win_lo;
            resp_id_q <= mem.id;
         end
         if (invert_prio_i != inv_q) begin
            state_q <= NORMAL;
            stall_q <= '0;
         end else begin
            stall_q <= stall_nxt;
            state_q <= (state_q == NORMAL) ? (starve ? FORCE : NORMAL) : ((s_hs | ~s_req) ? NORMAL : FORCE);
         end
      end
   end
endmodule

// File: tb/tb_hci_bank_starv_arbiter.sv
// tb_hci_bank_starv_arbiter: directed bench checked against a per-cycle reference model
module tb_hci_bank_starv_arbiter;
   localparam int AW = 32, DW = 32, BW = 8, IW = 8, STALL_W = 8;
   localparam int SAT = (1 << STALL_W) - 1;
   logic clk = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, invert_prio_i = 1'b0;
   logic [STALL_W-1:0] max_stall_i = '0;
   int n_cmp = 0, n_err = 0, cyc = 0;
   hci_bank_starv_arbiter_if #(.AW(AW), .DW(DW), .BW(BW), .IW(IW)) hi_if();
   hci_bank_starv_arbiter_if #(.AW(AW), .DW(DW), .BW(BW), .IW(IW)) lo_if();
   hci_bank_starv_arbiter_if #(.AW(AW), .DW(DW), .BW(BW), .IW(IW)) mem_if();
   hci_bank_starv_arbiter #(.AW(AW), .DW(DW), .BW(BW), .IW(IW), .STALL_W(STALL_W)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .invert_prio_i(invert_prio_i),
      .max_stall_i(max_stall_i), .hi(hi_if), .lo(lo_if), .mem(mem_if));
   always #5 clk = ~clk;
   // model state: forced flag, stall count, inversion seen last edge, pending response
   bit m_force, m_inv, m_pv;
   int m_stall, m_pside;
   logic [IW-1:0] m_pid;
   task automatic m_reset();
      m_force = 0; m_inv = 0; m_pv = 0; m_stall = 0; m_pside = 0; m_pid = '0;
   endtask
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask
   // per-cycle compare against the model; sides indexed 0 = hi, 1 = lo
   initial begin
      logic req [2];
      logic wen [2];
      logic [IW-1:0] id [2];
      logic [AW-1:0] add [2];
      logic [DW-1:0] dat [2];
      logic [DW/BW-1:0] be [2];
      int prim, sec, w;
      bit hs, sec_won;
      m_reset();
      forever begin
         @(negedge clk);
         if (!rst_ni) m_reset();
         req[0] = hi_if.req;  req[1] = lo_if.req;
         wen[0] = hi_if.wen;  wen[1] = lo_if.wen;
         id[0]  = hi_if.id;   id[1]  = lo_if.id;
         add[0] = hi_if.add;  add[1] = lo_if.add;
         dat[0] = hi_if.data; dat[1] = lo_if.data;
         be[0]  = hi_if.be;   be[1]  = lo_if.be;
         prim = invert_prio_i ? 1 : 0;
         sec = 1 - prim;
         if (m_force) w = req[sec] ? sec : prim;
         else w = req[prim] ? prim : sec;
         hs = req[w] && mem_if.gnt;
         chk("mem_req", mem_if.req, req[w]);
         chk("hi_gnt", hi_if.gnt, hs && w == 0);
         chk("lo_gnt", lo_if.gnt, hs && w == 1);
         if (req[w]) begin
            chk("mem_add", mem_if.add, add[w]);
            chk("mem_wen", mem_if.wen, wen[w]);
            chk("mem_data", mem_if.data, dat[w]);
            chk("mem_be", mem_if.be, be[w]);
            chk("mem_id", mem_if.id, id[w]);
         end
         chk("hi_r_valid", hi_if.r_valid, m_pv && m_pside == 0);
         chk("lo_r_valid", lo_if.r_valid, m_pv && m_pside == 1);
         if (m_pv && m_pside == 0) chk("hi_r_id", hi_if.r_id, m_pid);
         if (m_pv && m_pside == 1) chk("lo_r_id", lo_if.r_id, m_pid);
         chk("hi_r_data", hi_if.r_data, mem_if.r_data);
         chk("lo_r_data", lo_if.r_data, mem_if.r_data);
         chk("stall", dut.stall_q, m_stall);
         @(posedge clk);
         if (!rst_ni) m_reset();
         else if (clear_i) begin
            m_force = 0; m_stall = 0; m_pv = 0; m_inv = invert_prio_i;
         end else begin
            sec_won = hs && w == sec;
            if (invert_prio_i != m_inv) begin
               m_force = 0; m_stall = 0;
            end else begin
               if (!req[sec] || sec_won) m_stall = 0;
               else if (hs) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
               if (!m_force) m_force = (max_stall_i != 0) && (m_stall >= int'(max_stall_i));
               else m_force = req[sec] && !sec_won;
            end
            m_inv = invert_prio_i;
            m_pv = hs;
            if (hs) begin
               m_pside = w; m_pid = id[w];
            end
         end
      end
   end
   task automatic step();
      logic [31:0] c;
      @(posedge clk);
      #1;
      cyc++;
      c = cyc;
      hi_if.add = 32'h1000_0000 + c;
      lo_if.add = 32'h2000_0000 + c;
      hi_if.data = c * 3;
      lo_if.data = ~c;
      hi_if.be = c[3:0];
      lo_if.be = ~c[3:0];
      mem_if.r_data = 32'hd00d_0000 ^ c;
   endtask
   // directed stimulus with hand-computed literal expectations
   initial begin
      hi_if.req = 0; lo_if.req = 0; hi_if.wen = 1; lo_if.wen = 1;
      hi_if.id = 8'h01; lo_if.id = 8'h02; hi_if.add = '0; lo_if.add = '0;
      hi_if.data = '0; lo_if.data = '0; hi_if.be = '0; lo_if.be = '0;
      mem_if.gnt = 1; mem_if.r_data = '0; mem_if.r_valid = 0; mem_if.r_id = '0;
      repeat (3) step();
      #2;
      chk("rst hi_gnt", hi_if.gnt, 0);
      chk("rst lo_gnt", lo_if.gnt, 0);
      chk("rst mem_req", mem_if.req, 0);
      chk("rst hi_r_valid", hi_if.r_valid, 0);
      chk("rst lo_r_valid", lo_if.r_valid, 0);
      chk("rst hi_r_id", hi_if.r_id, 0);
      chk("rst lo_r_id", lo_if.r_id, 0);
      step(); rst_ni = 1;
      step(); hi_if.req = 1; lo_if.req = 1;
      for (int i = 0; i < 5; i++) begin
         step(); #2;
         chk("prio hi_gnt", hi_if.gnt, 1);
         chk("prio lo_gnt", lo_if.gnt, 0);
      end
      step(); invert_prio_i = 1; #2;
      chk("inv lo_gnt", lo_if.gnt, 1);
      chk("inv hi_gnt", hi_if.gnt, 0);
      repeat (3) step();
      step(); invert_prio_i = 0; hi_if.req = 0; lo_if.req = 0; max_stall_i = 3;
      for (int i = 0; i < 8; i++) begin
         step(); hi_if.req = 1; lo_if.req = 1; #2;
         chk("starve lo_gnt", lo_if.gnt, (i % 4) == 3);
         chk("starve hi_gnt", hi_if.gnt, (i % 4) != 3);
         if (i == 4) chk("starve stall cleared", dut.stall_q, 0);
      end
      step(); hi_if.req = 0; lo_if.req = 0; max_stall_i = 2;
      step(); hi_if.req = 1; lo_if.req = 1; #2;
      chk("abandon c1 hi_gnt", hi_if.gnt, 1);
      step(); #2;
      chk("abandon c2 hi_gnt", hi_if.gnt, 1);
      step(); lo_if.req = 0; #2;
      chk("abandon hi_gnt", hi_if.gnt, 1);
      chk("abandon lo_gnt", lo_if.gnt, 0);
      step(); lo_if.req = 1; #2;
      chk("abandon stall", dut.stall_q, 0);
      chk("abandon normal hi_gnt", hi_if.gnt, 1);
      step(); hi_if.req = 0; lo_if.req = 0; max_stall_i = 1;
      step(); hi_if.req = 1; hi_if.wen = 1; hi_if.id = 8'h11; lo_if.req = 1; lo_if.wen = 0; lo_if.id = 8'h22; #2;
      chk("route hi_gnt", hi_if.gnt, 1);
      step(); hi_if.req = 0; #2;
      chk("route lo_gnt", lo_if.gnt, 1);
      chk("route hi_r_valid", hi_if.r_valid, 1);
      chk("route hi_r_id", hi_if.r_id, 8'h11);
      chk("route lo_r_valid N+1", lo_if.r_valid, 0);
      step(); lo_if.req = 0; #2;
      chk("route lo_r_valid", lo_if.r_valid, 1);
      chk("route lo_r_id", lo_if.r_id, 8'h22);
      chk("route hi_r_valid N+2", hi_if.r_valid, 0);
      step(); lo_if.wen = 1; max_stall_i = 3; hi_if.id = 8'ha5; lo_if.id = 8'h5a;
      step(); hi_if.req = 1; lo_if.req = 1;
      step();
      for (int i = 0; i < 5; i++) begin
         step(); mem_if.gnt = 0; #2;
         chk("bp hi_gnt", hi_if.gnt, 0);
         chk("bp lo_gnt", lo_if.gnt, 0);
         chk("bp stall", dut.stall_q, 2);
      end
      step(); mem_if.gnt = 1; #2;
      chk("bp release hi_gnt", hi_if.gnt, 1);
      step(); mem_if.gnt = 0; clear_i = 1; #2;
      chk("clr force mem_id", mem_if.id, 8'h5a);
      step(); clear_i = 0; mem_if.gnt = 1; #2;
      chk("clr hi_gnt", hi_if.gnt, 1);
      chk("clr stall", dut.stall_q, 0);
      step(); max_stall_i = 0;
      repeat (4) step();
      step(); max_stall_i = 2; mem_if.gnt = 0;
      step(); mem_if.gnt = 1; #2;
      chk("lower max lo_gnt", lo_if.gnt, 1);
      step(); max_stall_i = 0;
      repeat (300) step();
      #2;
      chk("sat stall", dut.stall_q, 8'hff);
      step(); max_stall_i = 8'hff;
      step(); #2;
      chk("sat force lo_gnt", lo_if.gnt, 1);
      step(); max_stall_i = 0; #2;
      chk("rst mid hs", hi_if.gnt, 1);
      step(); rst_ni = 0; hi_if.req = 0; lo_if.req = 0; #2;
      chk("rst mid hi_r_valid", hi_if.r_valid, 0);
      chk("rst mid stall", dut.stall_q, 0);
      step(); step(); rst_ni = 1;
      step(); #2;
      chk("post rst hi_r_valid", hi_if.r_valid, 0);
      chk("post rst lo_r_valid", lo_if.r_valid, 0);
      for (int i = 0; i < 160; i++) begin
         step();
         hi_if.req = (i % 3) != 0;
         lo_if.req = (i % 5) != 1;
         mem_if.gnt = (i % 7) != 2;
         invert_prio_i = ((i / 40) % 2) == 1;
         max_stall_i = STALL_W'((i / 20) % 4);
         clear_i = (i == 77);
         hi_if.wen = i[0];
         lo_if.wen = i[1];
         hi_if.id = IW'(i);
         lo_if.id = IW'(255 - i);
      end
      step(); hi_if.req = 0; lo_if.req = 0; clear_i = 0;
      step(); step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
